// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit
//   Fetch front end. It owns the PC and drives two word addresses each cycle
//   (pc, pc+4) into a combinational dual-read instruction memory. The returned
//   words go into a circular queue of {instr, pc} entries. The two oldest
//   entries are presented to decode, which reports how many it consumed.
// Ports
//   i_clk, i_reset          : clock; asynchronous active-high reset
//   o_imem_addr0/1          : fetch addresses (pc, pc+4)
//   i_imem_data0/1          : instruction words for those addresses, same cycle
//   i_redirect_valid/_pc    : flush the queue and restart fetch at the target
//   o_out{0,1}_valid/instr/pc : queue head and head+1 entries for decode
//   i_dec_take              : number of entries decode consumes (0..2)
module dual_fetch_unit #(
  parameter int              XLEN        = 32,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic [XLEN-1:0] o_imem_addr0,
  output logic [XLEN-1:0] o_imem_addr1,
  input  logic [31:0]     i_imem_data0,
  input  logic [31:0]     i_imem_data1,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_out0_valid,
  output logic [31:0]     o_out0_instr,
  output logic [XLEN-1:0] o_out0_pc,
  output logic            o_out1_valid,
  output logic [31:0]     o_out1_instr,
  output logic [XLEN-1:0] o_out1_pc,
  input  logic [1:0]      i_dec_take
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;   // count spans 0..QUEUE_DEPTH
  localparam int SW = CW + 1;   // space spans 0..QUEUE_DEPTH+2

  logic [QUEUE_DEPTH-1:0][31:0]     r_q_instr;
  logic [QUEUE_DEPTH-1:0][XLEN-1:0] r_q_pc;
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc;

  logic [1:0]      w_take_c, w_eff, w_enq;
  logic [SW-1:0]   w_space;
  logic [XLEN-1:0] w_pc4;

  assign w_pc4        = r_pc + XLEN'(4);
  assign o_imem_addr0 = r_pc;
  assign o_imem_addr1 = w_pc4;

  // Clamp illegal requests: never more than two, never more than held.
  // Space counts slots freed this cycle, so a full queue drained by two is
  // refilled by two on the same edge.
  always_comb begin
    w_take_c = (i_dec_take == 2'd3) ? 2'd2 : i_dec_take;
    w_eff    = (CW'(w_take_c) > r_count) ? r_count[1:0] : w_take_c;
    w_space  = SW'(QUEUE_DEPTH) - SW'(r_count) + SW'(w_eff);
    w_enq    = (w_space >= SW'(2)) ? 2'd2 : w_space[1:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc    <= {RESET_PC[XLEN-1:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_redirect_valid) begin
      r_pc    <= {i_redirect_pc[XLEN-1:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_pc    <= r_pc + (XLEN'(w_enq) << 2);
      r_head  <= r_head + PW'(w_eff);
      r_tail  <= r_tail + PW'(w_enq);
      r_count <= r_count + CW'(w_enq) - CW'(w_eff);
    end
  end

  // Storage needs no reset: every read is gated by the count.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_redirect_valid) begin
      if (w_enq != 2'd0) begin
        r_q_instr[r_tail] <= i_imem_data0;
        r_q_pc[r_tail]    <= r_pc;
      end
      if (w_enq == 2'd2) begin
        r_q_instr[r_tail + PW'(1)] <= i_imem_data1;
        r_q_pc[r_tail + PW'(1)]    <= w_pc4;
      end
    end
  end

  // Decode-facing lanes: lane l shows entry head+l when count > l.
  logic [1:0]           w_lv;
  logic [1:0][31:0]     w_li;
  logic [1:0][XLEN-1:0] w_lp;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [PW-1:0] w_idx;
    assign w_idx   = r_head + PW'(l);
    assign w_lv[l] = (r_count > CW'(l));
    assign w_li[l] = w_lv[l] ? r_q_instr[w_idx] : '0;
    assign w_lp[l] = w_lv[l] ? r_q_pc[w_idx]    : '0;
  end

  assign o_out0_valid = w_lv[0];
  assign o_out0_instr = w_li[0];
  assign o_out0_pc    = w_lp[0];
  assign o_out1_valid = w_lv[1];
  assign o_out1_instr = w_li[1];
  assign o_out1_pc    = w_lp[1];

  // Decode asking for more than is held is a decode bug; the value is clamped
  // above, this only reports it.
  always @(posedge i_clk) begin
    if (!i_reset && !i_redirect_valid)
      assert ((i_dec_take != 2'd3) && (CW'(i_dec_take) <= r_count))
        else $warning("dec_take %0d exceeds available %0d, clamped", i_dec_take, r_count);
  end
endmodule

// File: tb/tb_dual_fetch_unit.sv
module tb_dual_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr0, imem_addr1, imem_data0, imem_data1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out0_valid, out1_valid;
  logic [31:0] out0_instr, out0_pc, out1_instr, out1_pc;
  logic [1:0]  dec_take = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hD000_0000;
  endfunction

  assign imem_data0 = mem(imem_addr0);
  assign imem_data1 = mem(imem_addr1);

  dual_fetch_unit #(.XLEN(32), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset(reset),
    .o_imem_addr0(imem_addr0), .o_imem_addr1(imem_addr1),
    .i_imem_data0(imem_data0), .i_imem_data1(imem_data1),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_out0_valid(out0_valid), .o_out0_instr(out0_instr), .o_out0_pc(out0_pc),
    .o_out1_valid(out1_valid), .o_out1_instr(out1_instr), .o_out1_pc(out1_pc),
    .i_dec_take(dec_take)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an ordered list of fetched {instr, pc} plus the next fetch pc.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_pc = 32'h0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      int take, n;
      take = (dec_take > 2) ? 2 : int'(dec_take);
      if (take > m_q.size()) take = m_q.size();
      for (int k = 0; k < take; k++) void'(m_q.pop_front());
      n = DEPTH - m_q.size();
      if (n > 2) n = 2;
      for (int k = 0; k < n; k++) begin
        m_q.push_back('{instr: mem(m_pc), pc: m_pc});
        m_pc = m_pc + 32'h4;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("addr0", imem_addr0, m_pc);
      chk("addr1", imem_addr1, m_pc + 32'h4);
      chk("out0_valid", 32'(out0_valid), 32'(m_q.size() >= 1));
      chk("out1_valid", 32'(out1_valid), 32'(m_q.size() >= 2));
      chk("out0_instr", out0_instr, (m_q.size() >= 1) ? m_q[0].instr : 32'h0);
      chk("out0_pc",    out0_pc,    (m_q.size() >= 1) ? m_q[0].pc    : 32'h0);
      chk("out1_instr", out1_instr, (m_q.size() >= 2) ? m_q[1].instr : 32'h0);
      chk("out1_pc",    out1_pc,    (m_q.size() >= 2) ? m_q[1].pc    : 32'h0);
    end
  end

  task automatic cyc(input logic [1:0] t, input logic rv, input logic [31:0] rp);
    dec_take = t; redirect_valid = rv; redirect_pc = rp;
    @(posedge clk);
    @(negedge clk);
    dec_take = '0; redirect_valid = 1'b0; redirect_pc = '0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_v0", 32'(out0_valid), 32'h0);
    chk("rst_v1", 32'(out1_valid), 32'h0);
    chk("rst_addr0", imem_addr0, 32'h0);
    chk("rst_pc0", out0_pc, 32'h0);
    reset = 1'b0;

    // fill from reset
    cyc(0, 0, 0);
    chk("t1_i0", out0_instr, 32'hD000_0000);
    chk("t1_p1", out1_pc, 32'h4);
    chk("t1_i1", out1_instr, 32'hD000_0004);
    cyc(0, 0, 0);
    chk("t1_full_a0", imem_addr0, 32'h10);
    cyc(0, 0, 0);
    chk("t1_hold_a0", imem_addr0, 32'h10);
    chk("t1_hold_p0", out0_pc, 32'h0);

    // sustained two per cycle
    cyc(2, 0, 0);
    chk("t2_p0", out0_pc, 32'h8);
    chk("t2_i1", out1_instr, 32'hD000_000C);
    chk("t2_a0", imem_addr0, 32'h18);
    cyc(2, 0, 0);
    chk("t2b_p0", out0_pc, 32'h10);
    chk("t2b_a0", imem_addr0, 32'h20);

    // redirect while full and decode taking two
    cyc(2, 1, 32'h1002);
    chk("t4_v0", 32'(out0_valid), 32'h0);
    chk("t4_a0", imem_addr0, 32'h1000);
    chk("t4_a1", imem_addr1, 32'h1004);
    cyc(0, 0, 0);
    chk("t4_p0", out0_pc, 32'h1000);
    chk("t4_p1", out1_pc, 32'h1004);

    // partial-space enqueue
    cyc(1, 0, 0);
    chk("t3_p0", out0_pc, 32'h1004);
    chk("t3_a0", imem_addr0, 32'h1010);
    cyc(0, 0, 0);
    chk("t3_one_a0", imem_addr0, 32'h1014);
    cyc(1, 0, 0);
    chk("t3_take1_p0", out0_pc, 32'h1008);
    chk("t3_take1_a0", imem_addr0, 32'h1018);

    // address wrap
    cyc(0, 1, 32'hFFFF_FFF8);
    chk("t5_a0", imem_addr0, 32'hFFFF_FFF8);
    cyc(0, 0, 0);
    chk("t5_p0", out0_pc, 32'hFFFF_FFF8);
    chk("t5_i0", out0_instr, 32'h2FFF_FFF8);
    chk("t5_p1", out1_pc, 32'hFFFF_FFFC);
    chk("t5_a0w", imem_addr0, 32'h0);

    // mid-stream asynchronous reset with three entries held
    cyc(0, 1, 32'h2000);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("t6_pre_v1", 32'(out1_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_v0", 32'(out0_valid), 32'h0);
    chk("t6_async_v1", 32'(out1_valid), 32'h0);
    chk("t6_async_a0", imem_addr0, 32'h0);
    chk("t6_async_i0", out0_instr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // over-asks get clamped
    cyc(2, 0, 0);
    chk("t6_clamp_p0", out0_pc, 32'h0);
    chk("t6_clamp_p1", out1_pc, 32'h4);
    cyc(3, 0, 0);
    chk("t6_take3_p0", out0_pc, 32'h8);
    chk("t6_take3_a0", imem_addr0, 32'h10);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule

// File: doc/dual_fetch_unit.md
Name: dual_fetch_unit

Overview:
- Front-end fetch stage of the superscalar core, directly upstream of the dual-read instruction memory.
- Owns the PC and drives both memory read addresses (PC, PC+4) each cycle. Memory reads are combinational.
- Captures the two returned instruction words into a small circular instruction queue.
- Presents up to two in-order instructions per cycle to decode; decode reports how many it consumed.

Parameters:
XLEN, XLEN_WIDTH (from common, 32), address/PC width
QUEUE_DEPTH, 4, instruction queue entries (power of two, >=2)
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_addr0  output  XLEN  byte address of fetch slot 0 (= pc)
imem_addr1  output  XLEN  byte address of fetch slot 1 (= pc+4)
imem_data0  input  32  instruction word at imem_addr0, same cycle
imem_data1  input  32  instruction word at imem_addr1, same cycle
redirect_valid  input  1  branch/jump redirect from execute
redirect_pc  input  XLEN  redirect target byte address
out0_valid  output  1  queue head entry valid
out0_instr  output  32  head instruction
out0_pc  output  XLEN  head instruction PC
out1_valid  output  1  second queue entry valid
out1_instr  output  32  second instruction
out1_pc  output  XLEN  second instruction PC
dec_take  input  2  instructions decode consumes this cycle (0,1,2)

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc=RESET_PC, head=tail=count=0.
  - out0_valid=out1_valid=0; all instr/pc outputs 0.
  - Takes effect immediately, not at the next edge.
- Addresses are combinational from registered pc: imem_addr0=pc, imem_addr1=pc+4, modulo 2^XLEN.
  - pc is always word aligned; bits [1:0] are held 0.
- Queue entry = {instr[31:0], pc[XLEN-1:0]}; circular buffer, head/tail pointers wrap modulo QUEUE_DEPTH.
- Outputs:
  - out0 = entry[head], out1 = entry[head+1 mod DEPTH], both driven straight from registers.
  - out0_valid = (count>=1), out1_valid = (count>=2).
  - Instr/pc outputs read 0 when the corresponding valid is 0.
- Dequeue:
  - eff_take = min(dec_take, count); head += eff_take.
  - dec_take > count or dec_take==3 is illegal: simulation assertion fires and the value is clamped.
  - dec_take==2 with only out0_valid takes 1.
- Enqueue (same cycle, no redirect): space = QUEUE_DEPTH - count + eff_take.
  - space>=2: write {imem_data0,pc} at tail and {imem_data1,pc+4} at tail+1; tail+=2; pc+=8.
  - space==1: write slot 0 only; tail+=1; pc+=4.
  - space==0: no write; pc holds (memory keeps being read at same pc).
- count_next = count + enq - eff_take; never exceeds QUEUE_DEPTH, never negative.
- Redirect (priority over enqueue and dequeue):
  - On the edge with redirect_valid=1: head=tail=count=0; pc=redirect_pc & ~3.
  - No enqueue; dec_take ignored.
  - Latency: redirect at edge N, valids low after N; target instructions enqueued at N+1; out0_valid high after N+1.
- Simultaneous full queue with dec_take=2: both slots freed and refilled in the same cycle (bypass of space computation); throughput sustained at 2 instr/cycle.
- The queue never contains non-sequential PCs except across a redirect, which flushes it.

Test Plan:
1. Reset, dec_take=0, memory holds words W0..W7 at 0x0..0x1C -> after edge 1 out0=W0@0x0, out1=W1@0x4; after edge 2 queue full (count 4), pc=0x10; pc holds thereafter, addr0 stays 0x10.
2. Steady dec_take=2 from full -> each cycle out0/out1 advance by 2 instructions (W2/W3, then W4/W5...), pc increments 8 per cycle, count stays 4.
3. Queue count 3, dec_take=0 -> only W at pc enqueued, pc+=4, count=4; then dec_take=1 -> one enqueued, count stays 4.
4. Redirect to 0x1002 while queue full and dec_take=2 -> next cycle valids 0, addr0=0x1000, addr1=0x1004; following cycle out0_pc=0x1000, out1_pc=0x1004.
5. pc=0xFFFF_FFF8 in a 32-bit run -> entries 0xFFFF_FFF8 and 0xFFFF_FFFC enqueued, pc wraps to 0x0000_0000.
6. Assert reset mid-stream with count=3 -> valids drop immediately without a clock edge, pc=RESET_PC; dec_take=2 with count=1 -> only 1 taken, assertion logged.
